// File: rtl/apb4_master_bridge.sv
// Single-outstanding command-to-APB4 initiator bridge.
// Runs IDLE/SETUP/ACCESS/RESP and can abort a stalled access on a timeout.
module apb4_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [2:0]              pprot,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int SW     = DATA_WIDTH / 8;
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  live_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [2:0]            prot_q, prot_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tout_q, tout_d;
    logic                  timed_out;

    // live_q keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            prot_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            prot_q  <= prot_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        prot_d  = prot_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tout_d  = tout_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && live_q) begin
                    write_d = req_write;
                    prot_d  = req_prot;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    strb_d  = req_write ? req_wstrb : '0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // a slave that answers on the threshold cycle still wins
                if (pready) begin
                    rdata_d = write_q ? '0 : prdata;
                    err_d   = pslverr;
                    tout_d  = 1'b0;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready   = live_q && (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = err_q;
    assign rsp_timeout = tout_q;

    assign psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable = (state_q == S_ACCESS);
    assign pwrite  = write_q;
    assign pprot   = prot_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign pstrb   = strb_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Randomized bench for apb4_master_bridge against a transaction-level model.
// DUT built with a 4-cycle timeout so abort and threshold paths are reachable.
module tb_apb4_master_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wstrb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [2:0]    pprot;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int vectors = 0;
    int miscompares = 0;

    logic [73:0] apb_act;
    assign apb_act = {psel, penable, pwrite, pprot, paddr, pwdata, pstrb};

    apb4_master_bridge #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_prot   (req_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pprot      (pprot),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 clk = ~clk;

    // One full transaction; the model says how many ACCESS cycles it lasts
    // (wt+1, or TO if the slave stalls past the limit) and what comes back.
    task automatic run_txn(input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           input logic [2:0] pr, input int wt,
                           input bit serr, input logic [31:0] rd,
                           input int rdly, input bit hold);
        bit          to;
        int          nacc;
        logic [73:0] exp_apb;
        logic [33:0] exp_rsp;
        to   = (wt >= TO);
        nacc = to ? TO : wt + 1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        req_prot  = pr;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        pready    = 1'($urandom);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: got %b want 1", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = hold;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        req_write = 1'($urandom);
        req_prot  = 3'($urandom);
        exp_apb = {1'b1, 1'b0, wr, pr, addr, wd, wr ? st : 4'h0};
        vectors++;
        if (apb_act !== exp_apb || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL setup: apb %h rdy %b rv %b want apb %h rdy 0 rv 0",
                     apb_act, req_ready, rsp_valid, exp_apb);
        end
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        exp_apb[72] = 1'b1;
        for (int k = 0; k < nacc; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (apb_act !== exp_apb || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL access%0d: apb %h rdy %b rv %b want apb %h rdy 0 rv 0",
                         k, apb_act, req_ready, rsp_valid, exp_apb);
            end
            if (!to && k == wt) begin
                pready  = 1'b1;
                pslverr = serr;
                prdata  = rd;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
        @(posedge clk); @(negedge clk);
        pready  = 1'($urandom);
        prdata  = $urandom;
        exp_apb[73:72] = 2'b00;
        exp_rsp = {(to || wr) ? 32'h0 : rd, to | serr, to};
        for (int d = 0; d <= rdly; d++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_error, rsp_timeout} !== exp_rsp
                || apb_act !== exp_apb || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL resp%0d: rv %b rsp %h apb %h rdy %b want rv 1 rsp %h apb %h rdy 0",
                         d, rsp_valid, {rsp_rdata, rsp_error, rsp_timeout}, apb_act,
                         req_ready, exp_rsp, exp_apb);
            end
            if (d == rdly) rsp_ready = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || apb_act !== exp_apb) begin
            miscompares++;
            $display("FAIL idle_after: rdy %b rv %b apb %h want rdy 1 rv 0 apb %h",
                     req_ready, rsp_valid, apb_act, exp_apb);
        end
    endtask

    task automatic test_reset();
        arst_n    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++;
        if (apb_act !== 74'h0 || req_ready !== 1'b0 || rsp_valid !== 1'b0
            || {rsp_rdata, rsp_error, rsp_timeout} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_state: apb %h rdy %b rv %b rsp %h want all 0",
                     apb_act, req_ready, rsp_valid, {rsp_rdata, rsp_error, rsp_timeout});
        end
        arst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_first_edge: got %b want 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_wait_write();
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_wait_read();
        // pready lands on the timeout threshold cycle and must still win
        run_txn(1'b0, 32'h24, 32'hA5A5A5A5, 4'hF, 3'd2, 3, 1'b0,
                32'h12345678, 1, 1'b0);
    endtask

    task automatic test_slverr();
        run_txn(1'b1, 32'h30, 32'h0BADF00D, 4'h3, 3'd5, 1, 1'b1, 32'h0, 2, 1'b1);
        run_txn(1'b0, 32'h34, 32'h0, 4'h0, 3'd1, 0, 1'b1, 32'hCAFEF00D, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h40, 32'h11111111, 4'h1, 3'd7, 9, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
        run_txn(1'b1, 32'h44, 32'h22222222, 4'hC, 3'd3, 4, 1'b0, 32'h0, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h50, 32'h0, 4'hF, 3'd4, 2, 1'b0, 32'h87654321, 5, 1'b1);
    endtask

    task automatic test_reset_mid_access();
        req_write = 1'b1;
        req_addr  = 32'h60;
        req_wdata = 32'h55AA55AA;
        req_wstrb = 4'hF;
        req_prot  = 3'd6;
        req_valid = 1'b1;
        pready    = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_access: sel/en %b want 11", {psel, penable});
        end
        #2 arst_n = 1'b0;
        #1;
        vectors++;
        if (apb_act !== 74'h0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_access: apb %h rdy %b rv %b want all 0",
                     apb_act, req_ready, rsp_valid);
        end
        @(negedge clk);
        pready    = 1'b1;
        arst_n    = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
                miscompares++;
                $display("FAIL no_rsp_after_reset%0d: rv %b psel %b want 0 0",
                         i, rsp_valid, psel);
            end
        end
        pready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(6, 0), 1'($urandom), $urandom,
                    $urandom_range(3, 0), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
